// File: rtl/i2s_tx_if.sv
// -----------------------------------------------------------------------------
// i2s_tx_if -- sample handshake between the distortion stage and i2s_tx.
//
// Signals:
//   in_data   [WIDTH-1:0]  two's-complement sample
//   in_valid               in_data holds a sample
//   in_ready               the transmitter accepts a sample this cycle
//
// Modports:
//   master  -- sample producer (drives in_data/in_valid, sees in_ready)
//   slave   -- i2s_tx          (sees in_data/in_valid, drives in_ready)
// -----------------------------------------------------------------------------
interface i2s_tx_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/i2s_tx.sv
// -----------------------------------------------------------------------------
// i2s_tx -- mono I2S transmitter (same sample on left and right channel).
//
// Parameters:
//   WIDTH     sample width in bits (two's complement)
//   BCLK_DIV  clk cycles per bclk half-period, 1..255
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   in_if         i2s_tx_if.slave sample handshake (in_data/in_valid/in_ready)
//   bclk          I2S bit clock (registered)
//   lrclk         I2S word select, 0 = left, 1 = right (registered)
//   sdata         I2S serial data, MSB first (registered)
//   underrun      one-clk pulse when a frame starts with no sample available
//   underrun_cnt  8-bit saturating underrun counter, present only when
//                 I2S_TX_UNDERRUN_CNT_EN is defined
//
// A single-entry holding register decouples the producer from the frame
// timing. A frame is 2*WIDTH bclk slots; the frame register is loaded on the
// bclk falling edge where the slot counter wraps to 0. An empty holding
// register at that edge is bypassed by a same-cycle transfer, otherwise the
// frame is sent as zeros and underrun pulses.
// -----------------------------------------------------------------------------
module i2s_tx #(
   parameter int WIDTH    = 16,
   parameter int BCLK_DIV = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   i2s_tx_if.slave    in_if,
   output logic       bclk,
   output logic       lrclk,
   output logic       sdata,
   output logic       underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
   ,
   output logic [7:0] underrun_cnt
`endif
);

   localparam int SLOTS = 2 * WIDTH;
   localparam int SW    = $clog2(SLOTS);
   localparam int IW    = $clog2(WIDTH);
   localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

   logic [7:0]       div_cnt;
   logic [SW-1:0]    slot;
   logic [WIDTH-1:0] frame;
   logic [WIDTH-1:0] hold;
   logic             hold_valid;

   logic             tick;        // divider terminal count: bclk toggles
   logic             fall;        // this edge drives bclk 1->0
   logic             load;        // frame load edge
   logic             xfer;        // handshake completes this edge
   logic             underrun_set;
   logic [SW-1:0]    slot_nxt;
   logic [WIDTH-1:0] frame_nxt;
   logic [IW-1:0]    bit_idx;
   logic             lrclk_nxt;

   assign in_if.in_ready = !hold_valid;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      tick         = (div_cnt == 8'(BCLK_DIV - 1));
      fall         = tick && bclk;
      load         = fall && (slot == LAST_SLOT);
      xfer         = in_if.in_valid && !hold_valid;
      underrun_set = load && !hold_valid && !xfer;
      slot_nxt     = load ? '0 : slot + 1'b1;
      frame_nxt    = frame;
      if (load) begin
         if (hold_valid)  frame_nxt = hold;
         else if (xfer)   frame_nxt = in_if.in_data;   // bypass the empty hold
         else             frame_nxt = '0;
      end
      // Left channel uses slots 0..WIDTH-1, right channel WIDTH..2*WIDTH-1,
      // both MSB first from the same frame word.
      if (slot_nxt < SW'(WIDTH)) bit_idx = IW'(SW'(WIDTH - 1) - slot_nxt);
      else                       bit_idx = IW'(LAST_SLOT - slot_nxt);
      // Word select leads each channel's MSB by one slot.
      lrclk_nxt = (slot_nxt >= SW'(WIDTH - 1)) && (slot_nxt <= SW'(SLOTS - 2));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt    <= '0;
         bclk       <= 1'b0;
         slot       <= LAST_SLOT;   // so the first bclk fall is a frame load
         // NOTE: data registers are reset too, so a reset mid-frame drops the held sample and sends no stale bits.
         frame      <= '0;
         hold       <= '0;
         hold_valid <= 1'b0;
         lrclk      <= 1'b0;
         sdata      <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values.
         underrun <= underrun_set;

         if (tick) begin
            div_cnt <= '0;
            bclk    <= !bclk;
         end else begin
            div_cnt <= div_cnt + 8'd1;
         end

         if (fall) begin
            slot  <= slot_nxt;
            frame <= frame_nxt;
            sdata <= frame_nxt[bit_idx];
            lrclk <= lrclk_nxt;
         end

         // in_ready is low whenever hold_valid is set, so a transfer never
         // collides with a held sample moving into the frame register.
         if (load) begin
            hold_valid <= 1'b0;
         end else if (xfer) begin
            hold       <= in_if.in_data;
            hold_valid <= 1'b1;
         end
      end
   end

`ifdef I2S_TX_UNDERRUN_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  underrun_cnt <= '0;
      else if (underrun_set && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_i2s_tx.sv
`timescale 1ns/1ps
module tb_i2s_tx;
   localparam int WIDTH     = 16;
   localparam int BCLK_DIV  = 2;
   localparam int SLOTS     = 2 * WIDTH;
   localparam int FRAME_CLK = 2 * BCLK_DIV * SLOTS;
   localparam logic [31:0] LR_PATTERN = 32'h0001_FFFE;  // lrclk=1 in slots 15..30

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic bclk, lrclk, sdata, underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
   logic [7:0] underrun_cnt;
`endif

   i2s_tx_if #(.WIDTH(WIDTH)) bus ();

   i2s_tx #(.WIDTH(WIDTH), .BCLK_DIV(BCLK_DIV)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_if    (bus),
      .bclk     (bclk),
      .lrclk    (lrclk),
      .sdata    (sdata),
      .underrun (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
      ,
      .underrun_cnt (underrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: cycle count since reset release, pending-sample queue,
   // and the sample carried by the current frame.
   int          n;
   logic [15:0] q[$];
   logic [15:0] cur_frame;
   logic [15:0] exp_frames[$];
   bit          exp_sdata, exp_lrclk, exp_underrun;
   int          exp_ucnt;
   int          m_slot;

   // Serial capture from the DUT pins, sampled while bclk is high.
   int          falls_seen;
   bit          bclk_prev;
   logic [31:0] cap_bits, cap_lr;
   logic [31:0] cap_frames[$];
   logic [31:0] cap_lrs[$];
   int          underrun_seen;
   int          cmp_idx;

   typedef enum {NONE, EARLY, ON_LOAD} mode_e;
   typedef struct {
      mode_e       mode;
      logic [15:0] data;
      logic [15:0] exp_word;
      int          exp_ur;
   } vec_t;
   vec_t tbl[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      n = 0;
      q.delete();
      exp_frames.delete();
      cur_frame = '0;
      exp_sdata = 0; exp_lrclk = 0; exp_underrun = 0;
      exp_ucnt = 0;
      m_slot = SLOTS - 1;
      falls_seen = 0; bclk_prev = 0;
      cap_bits = '0; cap_lr = '0;
      cap_frames.delete(); cap_lrs.delete();
      cmp_idx = 0;
   endtask

   // Assert reset (asynchronously, at a negedge), check outputs at once and
   // again after some cycles, then release at a negedge.
   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      #1;
      check("rst_bclk", bclk, 0);
      check("rst_lrclk", lrclk, 0);
      check("rst_sdata", sdata, 0);
      check("rst_underrun", underrun, 0);
      check("rst_in_ready", bus.in_ready, 1);
      repeat (cycles) @(negedge clk);
      check("rst_hold_bclk", bclk, 0);
      check("rst_hold_in_ready", bus.in_ready, 1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
      check("rst_underrun_cnt", underrun_cnt, 0);
`endif
      model_reset();
      rst_n = 1'b1;
   endtask

   // One clk cycle: drive inputs, advance the model on the edge, compare on
   // the following negedge.
   task automatic step(input bit v, input logic [15:0] d);
      bit ready_exp, xfer;
      int k;
      bus.in_valid = v;
      bus.in_data  = d;
      ready_exp = (q.size() == 0);
      check("in_ready", bus.in_ready, ready_exp);
      xfer = v && ready_exp;
      @(posedge clk);
      n++;
      exp_underrun = 0;
      if (n % (2 * BCLK_DIV) == 0) begin
         k = n / (2 * BCLK_DIV);
         m_slot = (k - 1) % SLOTS;
         if (m_slot == 0) begin
            if (q.size() > 0) cur_frame = q.pop_front();
            else if (xfer)    cur_frame = d;
            else begin
               cur_frame = '0;
               exp_underrun = 1;
               if (exp_ucnt < 255) exp_ucnt++;
            end
            exp_frames.push_back(cur_frame);
            xfer = 0;
         end
         exp_sdata = (m_slot < WIDTH) ? cur_frame[WIDTH-1-m_slot] : cur_frame[SLOTS-1-m_slot];
         exp_lrclk = (m_slot >= WIDTH - 1) && (m_slot <= SLOTS - 2);
      end
      if (xfer) q.push_back(d);
      @(negedge clk);
      check("bclk", bclk, (n / BCLK_DIV) % 2);
      check("lrclk", lrclk, exp_lrclk);
      check("sdata", sdata, exp_sdata);
      check("underrun", underrun, exp_underrun);
`ifdef I2S_TX_UNDERRUN_CNT_EN
      check("underrun_cnt", underrun_cnt, exp_ucnt);
`endif
      if (underrun) underrun_seen++;
      if (bclk_prev && !bclk) falls_seen++;
      if (!bclk_prev && bclk && falls_seen > 0) begin
         k = (falls_seen - 1) % SLOTS;
         cap_bits[SLOTS-1-k] = sdata;
         cap_lr[SLOTS-1-k]   = lrclk;
         if (k == SLOTS - 1) begin
            cap_frames.push_back(cap_bits);
            cap_lrs.push_back(cap_lr);
         end
      end
      bclk_prev = bclk;
   endtask

   task automatic compare_frames();
      while (cmp_idx < cap_frames.size() && cmp_idx < exp_frames.size()) begin
         check("frame_word", cap_frames[cmp_idx], {exp_frames[cmp_idx], exp_frames[cmp_idx]});
         check("frame_lrclk", cap_lrs[cmp_idx], LR_PATTERN);
         cmp_idx++;
      end
   endtask

   initial begin
      bit          v;
      bit          accepted;
      int          ur0, len, frames_before;
      logic [15:0] d;

      tbl[0] = '{EARLY,   16'h8001, 16'h8001, 0};
      tbl[1] = '{ON_LOAD, 16'h7FFF, 16'h7FFF, 0};
      tbl[2] = '{NONE,    16'h0000, 16'h0000, 1};
      tbl[3] = '{EARLY,   16'hA5C3, 16'hA5C3, 0};
      tbl[4] = '{ON_LOAD, 16'h0001, 16'h0001, 0};
      tbl[5] = '{NONE,    16'hFFFF, 16'h0000, 1};

      underrun_seen = 0;
      model_reset();
      do_reset(5);

      // Table: entry i spans the edges up to and including frame load i.
      for (int i = 0; i < 6; i++) begin
         ur0 = underrun_seen;
         len = (i == 0) ? 2 * BCLK_DIV : FRAME_CLK;
         for (int c = 0; c < len; c++) begin
            v = (tbl[i].mode == EARLY && c == 0) || (tbl[i].mode == ON_LOAD && c == len - 1);
            step(v, v ? tbl[i].data : 16'h0000);
         end
         check("tbl_underrun", underrun_seen - ur0, tbl[i].exp_ur);
      end
      for (int c = 0; c < FRAME_CLK; c++) step(0, 16'h0000);
      check("tbl_frame_count", cap_frames.size() >= 6, 1);
      for (int i = 0; i < 6; i++)
         if (i < cap_frames.size())
            check("tbl_word", cap_frames[i], {tbl[i].exp_word, tbl[i].exp_word});
      compare_frames();

      // Back-pressure: keep in_valid high with 0x1234, then 0x5678.
      frames_before = exp_frames.size();
      accepted = 0;
      for (int c = 0; c < 2 * FRAME_CLK && !accepted; c++) begin
         accepted = bus.in_ready;
         step(1, 16'h1234);
      end
      check("bp_accept_1234", accepted, 1);
      accepted = 0;
      for (int c = 0; c < 2 * FRAME_CLK && !accepted; c++) begin
         accepted = bus.in_ready;
         step(1, 16'h5678);
      end
      check("bp_accept_5678", accepted, 1);
      for (int c = 0; c < 2 * FRAME_CLK; c++) step(0, 16'h0000);
      check("bp_frame_count", cap_frames.size() >= frames_before + 2, 1);
      if (cap_frames.size() >= frames_before + 2) begin
         check("bp_first", cap_frames[frames_before], 32'h1234_1234);
         check("bp_second", cap_frames[frames_before+1], 32'h5678_5678);
      end
      compare_frames();

      // Randomized traffic at a sparse and a dense request rate.
      for (int c = 0; c < 6 * FRAME_CLK; c++) begin
         v = ($urandom_range(0, 99) < 2);
         d = 16'($urandom);
         step(v, d);
      end
      for (int c = 0; c < 6 * FRAME_CLK; c++) begin
         v = ($urandom_range(0, 99) < 50);
         d = 16'($urandom);
         step(v, d);
      end
      for (int c = 0; c < FRAME_CLK; c++) step(0, 16'h0000);
      compare_frames();

      // Mid-frame reset at slot 20 with a sample waiting in the hold register.
      step(1, 16'hBEEF);
      for (int c = 0; c < 2 * FRAME_CLK && m_slot != 20; c++) step(0, 16'h0000);
      check("mid_reach_slot20", m_slot, 20);
      compare_frames();
      do_reset(3);
      for (int c = 0; c < 2 * BCLK_DIV; c++) step(0, 16'h0000);
      check("mid_reset_underrun", underrun, 1);
      for (int c = 0; c < FRAME_CLK; c++) step(0, 16'h0000);
      check("mid_reset_frame_count", cap_frames.size() >= 1, 1);
      if (cap_frames.size() >= 1) check("mid_reset_zero_frame", cap_frames[0], 32'h0);
      compare_frames();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
